// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction prefetch FIFO between fetch and the IF/ID register.
//             Buffers {pc, inst, fault flags}; flushed on control-flow redirect.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int XLEN       = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_flush,

    input  logic                         i_enq_valid,
    input  logic [XLEN-1:0]              i_enq_pc,
    input  logic [INST_WIDTH-1:0]        i_enq_inst,
    input  logic                         i_enq_misaligned,
    input  logic                         i_enq_access_fault,
    output logic                         o_enq_ready,

    output logic                         o_deq_valid,
    output logic [XLEN-1:0]              o_deq_pc,
    output logic [XLEN-1:0]              o_deq_pc_4,
    output logic [INST_WIDTH-1:0]        o_deq_inst,
    output logic                         o_deq_misaligned,
    output logic                         o_deq_access_fault,
    input  logic                         i_deq_ready,

    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  C_FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ONE  = PTR_W'(1);
    localparam logic [XLEN-1:0]   C_PC_STEP  = XLEN'(4);

    // Entry storage: deliberately not reset, only the pointers/count are.
    logic [XLEN-1:0]       pc_mem_q   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
    logic                  mis_mem_q  [DEPTH];
    logic                  af_mem_q   [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic w_full;
    logic w_empty;
    logic w_enq_fire;
    logic w_deq_fire;
    logic w_wr_en;

    assign w_full     = (count_q == C_FULL);
    assign w_empty    = (count_q == '0);
    assign w_enq_fire = i_enq_valid && !w_full;
    assign w_deq_fire = !w_empty && i_deq_ready;
    assign w_wr_en    = w_enq_fire && !i_flush;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_enq_fire) begin
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_deq_fire) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            pc_mem_q[wr_ptr_q]   <= i_enq_pc;
            inst_mem_q[wr_ptr_q] <= i_enq_inst;
            mis_mem_q[wr_ptr_q]  <= i_enq_misaligned;
            af_mem_q[wr_ptr_q]   <= i_enq_access_fault;
        end
    end

    // Head data is zeroed whenever no entry is present.
    assign o_enq_ready        = !w_full;
    assign o_deq_valid        = !w_empty;
    assign o_deq_pc           = w_empty ? '0   : pc_mem_q[rd_ptr_q];
    assign o_deq_pc_4         = w_empty ? '0   : pc_mem_q[rd_ptr_q] + C_PC_STEP;
    assign o_deq_inst         = w_empty ? '0   : inst_mem_q[rd_ptr_q];
    assign o_deq_misaligned   = w_empty ? 1'b0 : mis_mem_q[rd_ptr_q];
    assign o_deq_access_fault = w_empty ? 1'b0 : af_mem_q[rd_ptr_q];
    assign o_count            = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Directed self-checking bench for fetch_queue with a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int IW    = 32;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b0;
    logic            i_flush = 1'b0;
    logic            i_enq_valid = 1'b0;
    logic [XLEN-1:0] i_enq_pc = '0;
    logic [IW-1:0]   i_enq_inst = '0;
    logic            i_enq_misaligned = 1'b0;
    logic            i_enq_access_fault = 1'b0;
    logic            o_enq_ready;
    logic            o_deq_valid;
    logic [XLEN-1:0] o_deq_pc;
    logic [XLEN-1:0] o_deq_pc_4;
    logic [IW-1:0]   o_deq_inst;
    logic            o_deq_misaligned;
    logic            o_deq_access_fault;
    logic            i_deq_ready = 1'b0;
    logic [2:0]      o_count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .INST_WIDTH(IW)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_flush            (i_flush),
        .i_enq_valid        (i_enq_valid),
        .i_enq_pc           (i_enq_pc),
        .i_enq_inst         (i_enq_inst),
        .i_enq_misaligned   (i_enq_misaligned),
        .i_enq_access_fault (i_enq_access_fault),
        .o_enq_ready        (o_enq_ready),
        .o_deq_valid        (o_deq_valid),
        .o_deq_pc           (o_deq_pc),
        .o_deq_pc_4         (o_deq_pc_4),
        .o_deq_inst         (o_deq_inst),
        .o_deq_misaligned   (o_deq_misaligned),
        .o_deq_access_fault (o_deq_access_fault),
        .i_deq_ready        (i_deq_ready),
        .o_count            (o_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [IW-1:0]   inst;
        logic            mis;
        logic            af;
    } entry_t;

    entry_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue updated on each edge from the pre-edge state.
    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mq.delete();
        end else if (i_flush) begin
            mq.delete();
        end else begin
            automatic bit e = i_enq_valid && (mq.size() < DEPTH);
            automatic bit d = i_deq_ready && (mq.size() != 0);
            automatic entry_t n;
            n.pc = i_enq_pc; n.inst = i_enq_inst;
            n.mis = i_enq_misaligned; n.af = i_enq_access_fault;
            if (d) void'(mq.pop_front());
            if (e) mq.push_back(n);
        end
    end

    always @(negedge i_clk) begin
        automatic bit v = (mq.size() != 0);
        automatic logic [XLEN-1:0] epc = v ? mq[0].pc : '0;
        automatic logic [XLEN-1:0] epc4 = v ? epc + 32'd4 : '0;
        chk("m_valid", 64'(o_deq_valid), 64'(v));
        chk("m_ready", 64'(o_enq_ready), 64'(mq.size() < DEPTH));
        chk("m_count", 64'(o_count), 64'(mq.size()));
        chk("m_pc",    64'(o_deq_pc), 64'(epc));
        chk("m_pc4",   64'(o_deq_pc_4), 64'(epc4));
        chk("m_inst",  64'(o_deq_inst), v ? 64'(mq[0].inst) : 64'd0);
        chk("m_mis",   64'(o_deq_misaligned), v ? 64'(mq[0].mis) : 64'd0);
        chk("m_af",    64'(o_deq_access_fault), v ? 64'(mq[0].af) : 64'd0);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic [XLEN-1:0] pc, input logic mis, input logic af);
        i_enq_valid = 1'b1;
        i_enq_pc = pc;
        i_enq_inst = pc ^ 32'hA5A5_0013;
        i_enq_misaligned = mis;
        i_enq_access_fault = af;
        step();
        i_enq_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst_valid", 64'(o_deq_valid), 64'd0);
        chk("rst_ready", 64'(o_enq_ready), 64'd1);
        chk("rst_count", 64'(o_count), 64'd0);
        i_rst = 1'b1;
        step();

        // Asynchronous reset mid-fill at count 3
        offer(32'h500, 1'b0, 1'b0);
        offer(32'h504, 1'b0, 1'b0);
        offer(32'h508, 1'b0, 1'b0);
        chk("pre_rst_count", 64'(o_count), 64'd3);
        #2 i_rst = 1'b0;
        #1;
        chk("arst_valid", 64'(o_deq_valid), 64'd0);
        chk("arst_count", 64'(o_count), 64'd0);
        chk("arst_ready", 64'(o_enq_ready), 64'd1);
        chk("arst_pc",    64'(o_deq_pc), 64'd0);
        step();
        i_rst = 1'b1;

        // Fill and drain
        i_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) offer(32'h100 + 32'(4 * i), (i == 1), 1'b0);
        chk("full_ready", 64'(o_enq_ready), 64'd0);
        chk("full_count", 64'(o_count), 64'd4);
        offer(32'h110, 1'b0, 1'b0);
        chk("over_count", 64'(o_count), 64'd4);
        chk("over_head",  64'(o_deq_pc), 64'h100);
        i_deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc",  64'(o_deq_pc), 64'(32'h100 + 32'(4 * i)));
            chk("drain_pc4", 64'(o_deq_pc_4), 64'(32'h104 + 32'(4 * i)));
            chk("drain_mis", 64'(o_deq_misaligned), 64'(i == 1));
            step();
        end
        chk("drained_valid", 64'(o_deq_valid), 64'd0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            offer(32'(4 * i), 1'b0, 1'b0);
            chk("stream_count", 64'(o_count), 64'd1);
            chk("stream_pc",    64'(o_deq_pc), 64'(4 * i));
        end
        step();
        chk("stream_empty", 64'(o_count), 64'd0);

        // Full plus simultaneous enqueue/dequeue
        i_deq_ready = 1'b0;
        for (int i = 0; i < 4; i++) offer(32'h180 + 32'(4 * i), 1'b0, 1'b0);
        i_deq_ready = 1'b1;
        offer(32'h200, 1'b0, 1'b0);
        chk("fs_count", 64'(o_count), 64'd3);
        chk("fs_ready", 64'(o_enq_ready), 64'd1);
        chk("fs_head",  64'(o_deq_pc), 64'h184);
        step();
        chk("fs2_count", 64'(o_count), 64'd2);

        // Flush priority over enqueue and dequeue
        i_flush = 1'b1;
        offer(32'h300, 1'b0, 1'b0);
        i_flush = 1'b0;
        chk("fl_count", 64'(o_count), 64'd0);
        chk("fl_valid", 64'(o_deq_valid), 64'd0);
        chk("fl_ready", 64'(o_enq_ready), 64'd1);
        i_deq_ready = 1'b0;
        offer(32'h400, 1'b0, 1'b0);
        chk("fl_next_head", 64'(o_deq_pc), 64'h400);
        i_deq_ready = 1'b1;
        step();
        i_deq_ready = 1'b0;

        // PC wrap and fault flags
        offer(32'hFFFF_FFFC, 1'b0, 1'b1);
        offer(32'h0, 1'b0, 1'b0);
        chk("wrap_pc4", 64'(o_deq_pc_4), 64'd0);
        chk("wrap_af",  64'(o_deq_access_fault), 64'd1);
        chk("wrap_inst", 64'(o_deq_inst), 64'(32'hFFFF_FFFC ^ 32'hA5A5_0013));
        i_deq_ready = 1'b1;
        step();
        chk("wrap2_pc",  64'(o_deq_pc), 64'd0);
        chk("wrap2_pc4", 64'(o_deq_pc_4), 64'd4);
        chk("wrap2_af",  64'(o_deq_access_fault), 64'd0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch FIFO between the instruction fetch unit / instruction memory and the IF/ID pipeline register. It buffers fetched `{pc, inst, fault flags}` entries so fetch can run ahead while IF/ID stalls. It is flushed on any control-flow redirect (taken branch, trap request, mret). It presents the head entry, with a derived `pc+4`, to IF/ID under a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `XLEN`, 32: PC width.
- `INST_WIDTH`, 32: instruction width.

Ports:
- `i_clk`  in  1  clock, all state updates on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `i_flush`  in  1  discard all entries (branch taken | trap_req | trap_mret).
- `i_enq_valid`  in  1  fetch side offers an entry.
- `i_enq_pc`  in  XLEN  PC of offered instruction.
- `i_enq_inst`  in  INST_WIDTH  instruction word.
- `i_enq_misaligned`  in  1  inst-address-misaligned flag for this fetch.
- `i_enq_access_fault`  in  1  inst-access-fault flag for this fetch.
- `o_enq_ready`  out  1  queue can accept an entry (not full).
- `o_deq_valid`  out  1  head entry present.
- `o_deq_pc`  out  XLEN  head PC.
- `o_deq_pc_4`  out  XLEN  head PC + 4.
- `o_deq_inst`  out  INST_WIDTH  head instruction.
- `o_deq_misaligned`  out  1  head misaligned flag.
- `o_deq_access_fault`  out  1  head access-fault flag.
- `i_deq_ready`  in  1  IF/ID consumes head (driven as !ifid_stall).
- `o_count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits plus an occupancy counter. Pointers wrap from DEPTH-1 to 0.
- Enqueue fires when `i_enq_valid && o_enq_ready`. The entry is written at `wr_ptr`, and `wr_ptr` increments.
- Dequeue fires when `o_deq_valid && i_deq_ready`, and `rd_ptr` increments.
- `o_enq_ready = (count != DEPTH)`. There is no pass-through when full: a dequeue in the same cycle does not make room until the next cycle.
- `o_deq_valid = (count != 0)`. There is no bypass when empty: an entry is visible only after it has been written.
- When both enqueue and dequeue fire, count is unchanged and both pointers advance.
- `o_deq_pc_4 = o_deq_pc + 4`, truncated to XLEN (modulo 2^XLEN), computed combinationally from the stored head PC.
- When `o_deq_valid = 0`, all `o_deq_*` data and flag outputs are driven to 0.
- Fault flags are stored per entry and travel with their instruction. The queue itself never raises or suppresses traps.
- Flush has priority over enqueue and dequeue. On an edge with `i_flush = 1`:
  - pointers and count go to 0;
  - a simultaneous enqueue is dropped;
  - a simultaneous dequeue handshake is not considered consumed by the queue (the consumer must also discard it).
- Entry storage is not cleared on flush or reset; only pointers and count are.
- Inputs `i_enq_*` must be stable while `i_enq_valid` is high. The queue does not require `i_enq_valid` to be held until accepted.

## Timing
- Reset (asynchronous assert, `i_rst = 0`):
  - `count = 0`, `rd_ptr = wr_ptr = 0`;
  - `o_deq_valid = 0`, all `o_deq_*` = 0;
  - `o_enq_ready = 1`, `o_count = 0`.
- Reset deassertion is synchronous to `i_clk`; the first enqueue can fire on the first edge after release.
- Latency: an entry enqueued at edge N appears on `o_deq_*` with `o_deq_valid = 1` in the cycle after edge N.
- Throughput: 1 entry/cycle sustained when 0 < count < DEPTH.
- Full boundary: at `count = DEPTH`, `o_enq_ready = 0`. After one dequeue edge, ready is 1 in the following cycle.
- Empty boundary: at `count = 1` with dequeue only, `o_deq_valid = 0` next cycle.
- Flush at edge N: in cycle N+1, `o_deq_valid = 0`, `o_enq_ready = 1`, `o_count = 0`. Enqueue may resume at edge N+1.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronously), independent of clock; stored contents become unreachable.
- All outputs are combinational from registered state only; there is no combinational path from `i_enq_*` or `i_deq_ready` to any output.

## Test plan
- Reset: hold `i_rst = 0` mid-fill with count = 3 → without a clock edge, `o_deq_valid = 0`, `o_count = 0`, `o_enq_ready = 1`, `o_deq_pc = 0`.
- Fill and drain: with `i_deq_ready = 0`, enqueue PCs 0x100, 0x104, 0x108, 0x10C. `o_enq_ready = 0` after the 4th; a 5th offer (0x110) is not accepted. Set `i_deq_ready = 1` → heads 0x100..0x10C in order with `o_deq_pc_4` = 0x104..0x110, then `o_deq_valid = 0`.
- Streaming wrap: continuous enqueue and dequeue of 10 sequential PCs from 0x0 → `o_count` stays 1 after the first edge; order is preserved across pointer wrap; no drops.
- Full + simultaneous: at count = 4, assert enqueue of 0x200 and dequeue together → head is consumed, 0x200 is not accepted, count = 3, `o_enq_ready = 1` next cycle.
- Flush priority: count = 2, assert `i_flush` together with enqueue of 0x300 and `i_deq_ready = 1` → next cycle count = 0, `o_deq_valid = 0`. A later enqueue of 0x400 is the next head.
- PC wrap and flags: enqueue pc 0xFFFFFFFC with `i_enq_access_fault = 1`, then pc 0x0 with no fault → first head shows `o_deq_pc_4 = 0x00000000` and `o_deq_access_fault = 1`; second head shows flag 0.
